// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester IDs and the
// default data-memory geometry.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 4;
    localparam int DMEM_DATA_W = 8;

    // Identifies which requester owns an access (used for read return routing)
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CORE = 2'd1,
        REQ_DBG  = 2'd2
    } req_id_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation tracker for the debug port: counts consecutive core grants that
// beat a waiting debug request, saturating at STARVE_LIM, and raises
// force_dbg once the limit is reached so the next contended grant goes to dbg.
module dmem_arb_starve_ctr #(
    parameter int STARVE_LIM = 3
) (
    input  logic clk,
    input  logic rs,
    input  logic dbg_req,
    input  logic core_gnt,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0] starve_cnt;

    // Count core wins over a waiting dbg request; any dbg service or dbg idle clears it
    always_ff @(posedge clk or negedge rs) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rs) begin
            starve_cnt <= '0;
        end else if (dbg_gnt || !dbg_req) begin
            starve_cnt <= '0;
        end else if (core_gnt && (starve_cnt != LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_dbg = (starve_cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core execute stage and the
// debug/DMA port. Fixed priority to core with a starvation guarantee for dbg;
// one access per cycle, read data routed back to its owner one cycle later.
// Optional grant statistics are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_e,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       core_gnt_cnt,
    output logic [15:0]       dbg_gnt_cnt,
    output logic              starve_evt,
`endif
    input  logic [DATA_W-1:0] mem_dout
);

    logic    force_dbg;
    req_id_e rd_owner;
    req_id_e rd_owner_next;

    dmem_arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk       (clk),
        .rs        (rs),
        .dbg_req   (dbg_req),
        .core_gnt  (core_gnt),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );

    // Same-cycle grant: core wins unless dbg is also asking and has starved; all grants held off in reset
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (rs) begin
            if (core_req && !(dbg_req && force_dbg)) begin
                core_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    // Route the granted port's access onto the memory; bus idles at zero
    always_comb begin
        mem_e    = core_gnt | dbg_gnt;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (core_gnt) begin
            mem_we   = core_we;
            mem_addr = core_addr;
            mem_din  = core_wdata;
        end else if (dbg_gnt) begin
            mem_we   = dbg_we;
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
        end
    end

    // Next read owner: whichever port was granted a read this cycle
    always_comb begin
        rd_owner_next = REQ_NONE;
        if (core_gnt && !core_we) begin
            rd_owner_next = REQ_CORE;
        end else if (dbg_gnt && !dbg_we) begin
            rd_owner_next = REQ_DBG;
        end
    end

    // Read owner register; reset drops any read still in flight
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            rd_owner <= REQ_NONE;
        end else begin
            rd_owner <= rd_owner_next;
        end
    end

    assign core_rvalid = (rd_owner == REQ_CORE);
    assign dbg_rvalid  = (rd_owner == REQ_DBG);
    assign core_rdata  = core_rvalid ? mem_dout : '0;
    assign dbg_rdata   = dbg_rvalid  ? mem_dout : '0;

`ifdef DMEM_ARB_STATS_EN
    // A forced dbg grant is one taken away from a requesting core
    assign starve_evt = dbg_gnt && core_req && force_dbg;

    // Free-running grant counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            core_gnt_cnt <= '0;
            dbg_gnt_cnt  <= '0;
        end else begin
            if (core_gnt) core_gnt_cnt <= core_gnt_cnt + 16'd1;
            if (dbg_gnt)  dbg_gnt_cnt  <= dbg_gnt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory + arbitration model predicts
// grants and bus contents per cycle; expected read returns go into per-port
// queues that an independent monitor drains whenever read data is due.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          rs  = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_e, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   core_gnt_cnt, dbg_gnt_cnt;
    logic          starve_evt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk         (clk),
        .rs          (rs),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_e       (mem_e),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
`ifdef DMEM_ARB_STATS_EN
        .core_gnt_cnt(core_gnt_cnt),
        .dbg_gnt_cnt (dbg_gnt_cnt),
        .starve_evt  (starve_evt),
`endif
        .mem_dout    (mem_dout)
    );

    // Environment: the 16x8 data memory with registered read data
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_e) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout <= mem[mem_addr];
        end
    end

    // Reference state
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic [DW-1:0] ref_mem [16];
    exp_t          core_q[$];
    exp_t          dbg_q[$];
    int            dbg_wait = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic          last_dbg_gnt = 1'b0;
    int            evt_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive requests, compare grants/bus with the model, update the model
    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        output logic cg, output logic dg);
        logic [1+1+AW+DW-1:0] exp_bus;
        @(negedge clk);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
        #1;
        dg = dr && (!cr || dbg_wait >= LIM);
        cg = cr && !dg;
        check("core_gnt", 32'(core_gnt), 32'(cg));
        check("dbg_gnt",  32'(dbg_gnt),  32'(dg));
        if (cg)      exp_bus = {1'b1, cw, ca, cd};
        else if (dg) exp_bus = {1'b1, dw, da, dd};
        else         exp_bus = '0;
        check("mem_bus", 32'({mem_e, mem_we, mem_addr, mem_din}), 32'(exp_bus));
        last_dbg_gnt = dbg_gnt;
`ifdef DMEM_ARB_STATS_EN
        check("starve_evt", 32'(starve_evt), 32'(dg && cr));
        if (starve_evt) evt_cnt++;
`endif
        if (cg) begin
            if (cw) ref_mem[ca] = cd;
            else    core_q.push_back('{ref_mem[ca], cyc});
        end
        if (dg) begin
            if (dw) ref_mem[da] = dd;
            else    dbg_q.push_back('{ref_mem[da], cyc});
        end
        if (dg || !dr)                  dbg_wait = 0;
        else if (cg && dbg_wait < LIM)  dbg_wait++;
    endtask

    // Monitor: read data must appear exactly one cycle after its grant, and nowhere else
    always @(negedge clk) begin : monitor
        exp_t e;
        if (core_q.size() > 0 && core_q[0].cyc == cyc - 1) begin
            e = core_q.pop_front();
            check("core_rvalid", 32'(core_rvalid), 32'd1);
            check("core_rdata",  32'(core_rdata),  32'(e.data));
        end else begin
            check("core_rvalid_idle", 32'(core_rvalid), 32'd0);
            check("core_rdata_idle",  32'(core_rdata),  32'd0);
        end
        if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc - 1) begin
            e = dbg_q.pop_front();
            check("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
            check("dbg_rdata",  32'(dbg_rdata),  32'(e.data));
        end else begin
            check("dbg_rvalid_idle", 32'(dbg_rvalid), 32'd0);
            check("dbg_rdata_idle",  32'(dbg_rdata),  32'd0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic          cg, dg;
        logic          pc, pcw, pd, pdw;
        logic [AW-1:0] pca, pda;
        logic [DW-1:0] pcd, pdd;
        logic [DW-1:0] pre;
        logic [1:0]    pat [8];
`ifdef DMEM_ARB_STATS_EN
        logic [15:0]   snap_c, snap_d;
`endif
        cg = 1'b0; dg = 1'b0;

        // Reset: requests asserted, yet no grant, no enable, no read data
        repeat (2) @(negedge clk);
        core_req = 1'b1; dbg_req = 1'b1;
        #1;
        check("rst_core_gnt", 32'(core_gnt), 32'd0);
        check("rst_dbg_gnt",  32'(dbg_gnt),  32'd0);
        check("rst_mem_e",    32'(mem_e),    32'd0);
        check("rst_rvalid",   32'({core_rvalid, dbg_rvalid}), 32'd0);
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rs = 1'b1;

        // Preload all locations through the dbg port
        for (int i = 0; i < 16; i++) begin
            if (i < 3)       pre = 8'h10 + 8'(i);
            else if (i == 3) pre = 8'hA5;
            else             pre = 8'($urandom);
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'(i), pre, cg, dg);
        end

        // Core read of addr 3 (holds A5)
        step(1'b1, 1'b0, 4'h3, '0, 1'b0, 1'b0, '0, '0, cg, dg);
        // dbg writes 5C to addr 7, core reads it in the following cycle
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'h7, 8'h5C, cg, dg);
        step(1'b1, 1'b0, 4'h7, '0, 1'b0, 1'b0, '0, '0, cg, dg);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);

        // Continuous contention: dbg wins every fourth cycle
        pat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
`ifdef DMEM_ARB_STATS_EN
        snap_c = core_gnt_cnt; snap_d = dbg_gnt_cnt; evt_cnt = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'(i), '0, 1'b1, 1'b0, 4'(i + 8), '0, cg, dg);
            check("contention_pattern", 32'(last_dbg_gnt), 32'(pat[i][0]));
        end
`ifdef DMEM_ARB_STATS_EN
        @(posedge clk); #1;
        check("stats_core_cnt", 32'(16'(core_gnt_cnt - snap_c)), 32'd6);
        check("stats_dbg_cnt",  32'(16'(dbg_gnt_cnt - snap_d)),  32'd2);
        check("stats_evt_cnt",  32'(evt_cnt), 32'd2);
`endif
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);

        // Back-to-back dbg reads of 0,1,2 (10,11,12)
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'(i), '0, cg, dg);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);

        // Build up starvation, then reset right after a granted core read
        step(1'b1, 1'b1, 4'h9, 8'h33, 1'b1, 1'b0, 4'h2, '0, cg, dg);
        step(1'b1, 1'b0, 4'h9, '0, 1'b1, 1'b0, 4'h2, '0, cg, dg);
        @(posedge clk);
        #1;
        rs = 1'b0;
        core_q.delete(); dbg_q.delete(); dbg_wait = 0;
        #1;
        check("midrst_core_rvalid", 32'(core_rvalid), 32'd0);
        check("midrst_mem_e",       32'(mem_e),       32'd0);
        check("midrst_gnt",         32'({core_gnt, dbg_gnt}), 32'd0);
        @(negedge clk);
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rs = 1'b1;
        // Counter restarted: three core wins before dbg
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 4'(i), '0, 1'b1, 1'b0, 4'(15 - i), '0, cg, dg);
            check("postrst_pattern", 32'(last_dbg_gnt), 32'(i == 3));
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);

        // Randomized traffic obeying the hold-until-grant handshake
        pc = 1'b0; pd = 1'b0; pcw = 1'b0; pdw = 1'b0;
        pca = '0; pda = '0; pcd = '0; pdd = '0;
        cg = 1'b0; dg = 1'b0;
        repeat (600) begin
            if (!pc || cg) begin
                pc = ($urandom % 4) != 0; pcw = 1'($urandom); pca = 4'($urandom); pcd = 8'($urandom);
            end else if (($urandom % 12) == 0) begin
                pc = 1'b0;
            end
            if (!pd || dg) begin
                pd = ($urandom % 3) != 0; pdw = 1'($urandom); pda = 4'($urandom); pdd = 8'($urandom);
            end else if (($urandom % 12) == 0) begin
                pd = 1'b0;
            end
            step(pc, pcw, pca, pcd, pd, pdw, pda, pdd, cg, dg);
        end
        repeat (2) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);
        @(negedge clk);
        #1;
        check("core_q_drained", 32'(core_q.size()), 32'd0);
        check("dbg_q_drained",  32'(dbg_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16x8 data memory between two requesters: the core's execute-stage access (core port) and a debug/DMA port (dbg port) used for inspecting and preloading data memory.
- Sits between the control unit/datapath and data_mem.
- Issues at most one memory access per cycle and returns read data to the owner one cycle later.
- Fixed priority to core, with a starvation counter that guarantees dbg service.

Parameters:
- ADDR_W, 4, data memory address width.
- DATA_W, 8, data word width.
- STARVE_LIM, 3, consecutive core grants while dbg is waiting before dbg is forced a grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rs  in  1  asynchronous active-low reset.
- core_req  in  1  core access request; held with its attributes until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  access issued this cycle.
- core_rvalid  out  1  read data valid, one cycle after a granted read.
- core_rdata  out  DATA_W  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same semantics as core.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  same semantics as core.
- mem_e  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data; registered, valid the cycle after a read with mem_e=1.

Behaviour:
- Reset (rs=0, asynchronous):
  - starve_cnt=0; rd_owner=NONE.
  - core_rvalid=0, dbg_rvalid=0.
  - Grants and mem_e/mem_we are forced 0.
  - rdata outputs read 0 while their rvalid is 0.
- Grant decision is combinational within the cycle:
  - Only core_req: core_gnt=1.
  - Only dbg_req: dbg_gnt=1.
  - Both, starve_cnt<STARVE_LIM: core_gnt=1.
  - Both, starve_cnt==STARVE_LIM: dbg_gnt=1.
  - Neither: no grant, mem_e=0.
- Mem mux:
  - The granted port's addr/we/wdata drive mem_addr/mem_we/mem_din; mem_e=1.
  - With no grant, mem_addr, mem_din and mem_we are 0.
- Starvation counter (registered):
  - Core granted while dbg_req=1: increment, saturating at STARVE_LIM.
  - dbg granted: cleared to 0.
  - dbg_req=0: cleared to 0.
- Read return state machine, rd_owner in {NONE, CORE, DBG}, registered:
  - A granted read sets rd_owner to the granting port for the next cycle; otherwise NONE.
  - When rd_owner=CORE: core_rvalid=1 and core_rdata=mem_dout. DBG is symmetric.
  - Back-to-back reads are allowed; a new grant in the same cycle as an rvalid is legal.
- Writes complete at the grant edge; no rvalid is produced.
- Latency: grant in cycle 0 (0-cycle arbitration); read data at cycle 1.
- Handshake rules:
  - A requester keeps req/attributes stable until it sees gnt.
  - Deasserting req before gnt is legal and means the request is withdrawn.
  - req held after gnt is a new request.
- Boundary conditions:
  - Addresses wrap naturally within ADDR_W.
  - Same-address write by one port and read by the other in consecutive cycles: the read returns the new data.
  - Reset asserted mid-read: the pending rvalid is dropped.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds outputs:
  - core_gnt_cnt (16 bits): count of core grants, wraps at 0xFFFF->0, reset 0.
  - dbg_gnt_cnt (16 bits): count of dbg grants, wraps at 0xFFFF->0, reset 0.
  - starve_evt (1 bit): pulses one cycle whenever a dbg grant is forced by starve_cnt==STARVE_LIM.
- When undefined, these ports and their registers do not exist; arbitration is identical.

Decomposition:
- Shared package:
  - Requester ID encoding (NONE=2'd0, CORE=2'd1, DBG=2'd2).
  - DMEM_ADDR_W=4 and DMEM_DATA_W=8 constants.
- One natural sub-module, dmem_arb_starve_ctr: the saturating starvation counter plus the forced-grant flag.
- Everything else stays in the top module.

Test Plan:
- Core read only: core_req=1, core_we=0, addr=4'h3, mem holds 8'hA5 -> core_gnt same cycle, mem_addr=3; next cycle core_rvalid=1, core_rdata=8'hA5; dbg_rvalid=0.
- Dbg write then core read of the same location: dbg writes 8'h5C to addr 7, core reads addr 7 next cycle -> core_rdata=8'h5C.
- Continuous contention, both req=1 every cycle with STARVE_LIM=3 -> grant pattern core,core,core,dbg repeating; starve_cnt 0,1,2,3,0.
- Back-to-back dbg reads of addrs 0,1,2 (contents 8'h10,8'h11,8'h12) -> dbg_rvalid high for 3 consecutive cycles with data 10,11,12 in order.
- rs pulsed low asynchronously one cycle after a granted core read -> core_rvalid stays 0, starve_cnt=0, mem_e=0 during reset.
- With DMEM_ARB_STATS_EN, run the contention test for 8 cycles -> core_gnt_cnt=6, dbg_gnt_cnt=2, starve_evt pulsed twice.
